// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store controller with LDI/STI indirection, alignment and timeout faults
module mem_access_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic                    req_byte,
  input  logic                    req_signed,
  input  logic                    req_indirect,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    stall,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic                    fault,
  output logic [1:0]              fault_code,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_resp,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int OW    = $clog2(LANES);
  localparam int CW    = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, PTR_RD, ACCESS, DONE} state_t;
  state_t state, next;
  logic                  r_write, r_byte, r_signed, flt;
  logic [1:0]            code;
  logic [DATA_WIDTH-1:0] r_wdata, result;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0]         cnt;
  logic [OW-1:0]         off;
  logic [7:0]            lane_byte;
  logic                  req_mis, ptr_mis, expire;
  assign off       = addr[OW-1:0];
  assign lane_byte = mem_rdata[{off, 3'b000} +: 8];
  assign req_mis   = (!req_byte || req_indirect) && req_addr[OW-1:0] != '0;
  assign ptr_mis   = !r_byte && mem_rdata[OW-1:0] != '0;
  // a response in the expiry cycle suppresses the timeout
  assign expire    = TIMEOUT_CYCLES > 0 && !mem_resp && cnt == CW'(TIMEOUT_CYCLES - 1);
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= next;
  // next-state logic; DONE always returns to IDLE so a held request is not re-accepted
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = !req_valid ? IDLE : req_mis ? DONE : req_indirect ? PTR_RD : ACCESS;
      PTR_RD:  next = mem_resp ? (ptr_mis ? DONE : ACCESS) : expire ? DONE : PTR_RD;
      ACCESS:  next = (mem_resp || expire) ? DONE : ACCESS;
      default: next = IDLE;
    endcase
  end
  // request latch, effective address, timeout counter and result capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_write  <= 1'b0;
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
      r_wdata  <= '0;
      addr     <= '0;
      cnt      <= '0;
      result   <= '0;
      flt      <= 1'b0;
      code     <= 2'b00;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r_write  <= req_write;
          r_byte   <= req_byte;
          r_signed <= req_signed;
          r_wdata  <= req_wdata;
          addr     <= req_addr;
          cnt      <= '0;
          result   <= '0;
          flt      <= req_mis;
          code     <= req_mis ? 2'b01 : 2'b00;
        end
        PTR_RD: if (mem_resp) begin
          addr <= mem_rdata[ADDR_WIDTH-1:0];
          cnt  <= '0;
          flt  <= ptr_mis;
          code <= ptr_mis ? 2'b01 : 2'b00;
        end else if (expire) begin
          flt  <= 1'b1;
          code <= 2'b10;
        end else cnt <= cnt + 1'b1;
        ACCESS: if (mem_resp) begin
          result <= r_write ? '0 :
                    r_byte  ? {{(DATA_WIDTH-8){r_signed & lane_byte[7]}}, lane_byte} : mem_rdata;
        end else if (expire) begin
          flt  <= 1'b1;
          code <= 2'b10;
        end else cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  // outputs: strobes only in PTR_RD/ACCESS, everything quiet while reset is held
  always_comb begin
    mem_read    = state == PTR_RD || (state == ACCESS && !r_write);
    mem_write   = state == ACCESS && r_write;
    mem_wmask   = mem_write ? (r_byte ? LANES'(1) << off : '1) : '0;
    mem_address = (state == PTR_RD || state == ACCESS) ? addr : '0;
    mem_wdata   = mem_write ? (r_byte ? {LANES{r_wdata[7:0]}} : r_wdata) : '0;
    done        = state == DONE;
    stall       = req_valid && state != DONE && !reset;
    fault       = flt;
    fault_code  = code;
    load_data   = result;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of loads, stores, indirection, faults, timeout and reset
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_byte, req_signed, req_indirect;
  logic [15:0] req_addr, req_wdata;
  logic        stall, done, fault, mem_read, mem_write, mem_resp;
  logic [1:0]  fault_code, mem_wmask;
  logic [15:0] load_data, mem_address, mem_wdata, mem_rdata;
  logic [3:0]  sts;
  int          n_cmp = 0, n_err = 0;

  mem_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write), .req_byte(req_byte),
    .req_signed(req_signed), .req_indirect(req_indirect), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .load_data(load_data), .fault(fault), .fault_code(fault_code),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;
  assign sts = {stall, done, mem_read, mem_write};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_write = 0; req_byte = 0; req_signed = 0; req_indirect = 0;
    req_addr = 0; req_wdata = 0; mem_resp = 0; mem_rdata = 0;
  endtask

  task automatic set_req(input logic w, input logic b, input logic s, input logic ind,
                         input logic [15:0] a, input logic [15:0] wd);
    req_valid = 1; req_write = w; req_byte = b; req_signed = s; req_indirect = ind;
    req_addr = a; req_wdata = wd;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    #2;
    n_cmp++; if ({stall, done, fault, fault_code, mem_read, mem_write, mem_wmask} !== 9'd0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0", {stall, done, fault, fault_code, mem_read, mem_write, mem_wmask}); end
    n_cmp++; if ({load_data, mem_address, mem_wdata} !== 48'd0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {load_data, mem_address, mem_wdata}); end
    req_valid = 1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    req_valid = 0;
    tick();
    reset = 0;
    mem_resp = 1;
    tick();
    n_cmp++; if (sts !== 4'b0000) begin n_err++; $display("FAIL idle_resp_ignored: got %b want 0000", sts); end
    mem_resp = 0;
  endtask

  task automatic test_word_load();
    set_req(0, 0, 0, 0, 16'h3000, 16'h0);
    #1;
    n_cmp++; if (sts !== 4'b1000) begin n_err++; $display("FAIL wl_c1: got %b want 1000", sts); end
    tick();
    n_cmp++; if ({sts, mem_address} !== {4'b1010, 16'h3000}) begin
      n_err++; $display("FAIL wl_c2: got %h want a3000", {sts, mem_address}); end
    mem_resp = 1; mem_rdata = 16'hBEEF;
    tick();
    n_cmp++; if ({sts, fault, load_data} !== {4'b0100, 1'b0, 16'hBEEF}) begin
      n_err++; $display("FAIL wl_done: got %h want %h", {sts, fault, load_data}, {4'b0100, 1'b0, 16'hBEEF}); end
    idle_inputs();
    tick();
    n_cmp++; if (sts !== 4'b0000) begin n_err++; $display("FAIL wl_after: got %b want 0000", sts); end
  endtask

  task automatic test_byte_store();
    set_req(1, 1, 0, 0, 16'h1235, 16'h00A5);
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({sts, mem_wmask, mem_wdata, mem_address} !== {4'b1001, 2'b10, 16'hA5A5, 16'h1235}) begin
        n_err++; $display("FAIL bs_cyc%0d: got %h want %h", i, {sts, mem_wmask, mem_wdata, mem_address},
                          {4'b1001, 2'b10, 16'hA5A5, 16'h1235}); end
      if (i == 2) mem_resp = 1;
      tick();
    end
    n_cmp++; if ({sts, fault, load_data} !== {4'b0100, 1'b0, 16'h0}) begin
      n_err++; $display("FAIL bs_done: got %h want %h", {sts, fault, load_data}, {4'b0100, 1'b0, 16'h0}); end
    idle_inputs();
    tick();
  endtask

  task automatic test_byte_load(input logic sgn, input logic [15:0] exp);
    set_req(0, 1, sgn, 0, 16'h0101, 16'h0);
    tick();
    n_cmp++; if ({sts, mem_address} !== {4'b1010, 16'h0101}) begin
      n_err++; $display("FAIL bl_access: got %h want a0101", {sts, mem_address}); end
    mem_resp = 1; mem_rdata = 16'h80FF;
    tick();
    n_cmp++; if ({sts, load_data} !== {4'b0100, exp}) begin
      n_err++; $display("FAIL bl_done signed=%0d: got %h want %h", sgn, {sts, load_data}, {4'b0100, exp}); end
    idle_inputs();
    tick();
  endtask

  task automatic test_sti(input logic [15:0] ptr, input logic bad);
    set_req(1, 0, 0, 1, 16'h2000, 16'h1234);
    tick();
    n_cmp++; if ({sts, mem_address, mem_wmask} !== {4'b1010, 16'h2000, 2'b00}) begin
      n_err++; $display("FAIL sti_ptr: got %h want %h", {sts, mem_address, mem_wmask}, {4'b1010, 16'h2000, 2'b00}); end
    mem_resp = 1; mem_rdata = ptr;
    tick();
    if (!bad) begin
      n_cmp++; if ({sts, mem_address, mem_wmask, mem_wdata} !== {4'b1001, 16'h4002, 2'b11, 16'h1234}) begin
        n_err++; $display("FAIL sti_write: got %h want %h", {sts, mem_address, mem_wmask, mem_wdata},
                          {4'b1001, 16'h4002, 2'b11, 16'h1234}); end
      tick();
      n_cmp++; if ({sts, fault, fault_code} !== {4'b0100, 3'b000}) begin
        n_err++; $display("FAIL sti_done: got %b want 0100000", {sts, fault, fault_code}); end
    end else begin
      n_cmp++; if ({sts, fault, fault_code} !== {4'b0100, 3'b101}) begin
        n_err++; $display("FAIL sti_misaligned: got %b want 0100101", {sts, fault, fault_code}); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_misaligned();
    set_req(0, 0, 0, 0, 16'h0003, 16'h0);
    #1;
    n_cmp++; if (sts !== 4'b1000) begin n_err++; $display("FAIL mis_c1: got %b want 1000", sts); end
    tick();
    n_cmp++; if ({sts, fault, fault_code} !== {4'b0100, 3'b101}) begin
      n_err++; $display("FAIL mis_done: got %b want 0100101", {sts, fault, fault_code}); end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout(input logic resp_last);
    set_req(0, 0, 0, 0, 16'h0040, 16'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (sts !== 4'b1010) begin n_err++; $display("FAIL to_strobe%0d: got %b want 1010", i, sts); end
      if (resp_last && i == 3) begin mem_resp = 1; mem_rdata = 16'h1357; end
      tick();
    end
    n_cmp++; if ({sts, fault, fault_code, load_data} !== {4'b0100, resp_last ? 3'b000 : 3'b110, resp_last ? 16'h1357 : 16'h0}) begin
      n_err++; $display("FAIL to_done resp=%0d: got %h want %h", resp_last, {sts, fault, fault_code, load_data},
                        {4'b0100, resp_last ? 3'b000 : 3'b110, resp_last ? 16'h1357 : 16'h0}); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(0, 0, 0, 0, 16'h0200, 16'h0);
    tick();
    n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rm_read: got %b want 1", mem_read); end
    #2 reset = 1;
    #1;
    n_cmp++; if ({stall, done, mem_read} !== 3'b000) begin
      n_err++; $display("FAIL rm_drop: got %b want 000", {stall, done, mem_read}); end
    #1 reset = 0;
    #1;
    n_cmp++; if (sts !== 4'b1000) begin n_err++; $display("FAIL rm_idle: got %b want 1000", sts); end
    tick();
    n_cmp++; if ({sts, mem_address} !== {4'b1010, 16'h0200}) begin
      n_err++; $display("FAIL rm_access: got %h want a0200", {sts, mem_address}); end
    mem_resp = 1; mem_rdata = 16'h0ABC;
    tick();
    n_cmp++; if ({sts, fault, load_data} !== {4'b0100, 1'b0, 16'h0ABC}) begin
      n_err++; $display("FAIL rm_done: got %h want %h", {sts, fault, load_data}, {4'b0100, 1'b0, 16'h0ABC}); end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_byte_load(1'b1, 16'hFF80);
    test_byte_load(1'b0, 16'h0080);
    test_sti(16'h4002, 1'b0);
    test_sti(16'h4003, 1'b1);
    test_misaligned();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Parametrised MEM-stage access controller for the LC-3b pipeline and its wider variants. It replaces the ad-hoc indirect flag and combinational read/write steering of the current MEM datapath with an explicit FSM. It covers word/byte loads and stores, LDI/STI two-phase indirection, misalignment faults and a response timeout. It sits between the EX/MEM pipeline register and the data-memory port, and stalls the pipeline until each access retires.

Parameters:
DATA_WIDTH, 16, data bus width; multiple of 8, ≥16; LANES = DATA_WIDTH/8.
ADDR_WIDTH, 16, byte-address width.
TIMEOUT_CYCLES, 0, max cycles waiting for mem_resp per memory phase; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  MEM-stage instruction needs memory; held stable while stall=1.
req_write  in  1  1=store, 0=load.
req_byte  in  1  1=byte access, 0=word access.
req_signed  in  1  byte load sign-extends when 1, zero-extends when 0.
req_indirect  in  1  LDI/STI: req_addr points to the effective address.
req_addr  in  ADDR_WIDTH  address (or pointer address).
req_wdata  in  DATA_WIDTH  store data; byte stores use bits [7:0].
stall  out  1  freeze upstream stages.
done  out  1  one-cycle pulse: access retired.
load_data  out  DATA_WIDTH  aligned/extended load result, valid while done=1.
fault  out  1  with done: access aborted.
fault_code  out  2  01 misaligned, 10 timeout, 00 none.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
mem_wmask  out  LANES  byte-lane write enables.
mem_address  out  ADDR_WIDTH  memory address.
mem_wdata  out  DATA_WIDTH  memory write data.
mem_resp  in  1  memory completes the current strobe.
mem_rdata  in  DATA_WIDTH  read data, valid with mem_resp.

Behaviour:
- States: IDLE, PTR_RD, ACCESS, DONE. Reset: state IDLE; all outputs 0; internal registers (request, effective address, result, timeout counter) cleared.
- Lane offset = addr[log2(LANES)-1:0]. Word aligned ⇔ offset == 0.
- IDLE, req_valid=1: latch the request and clear the timeout counter.
  - Word access with an unaligned address, or indirect with an unaligned pointer: go to DONE with fault=1, code 01. No memory strobe.
  - Indirect: go to PTR_RD.
  - Otherwise: effective address = req_addr; go to ACCESS.
- PTR_RD: mem_read=1, mem_address = pointer (word), mem_wmask=0.
  - On mem_resp: effective address = mem_rdata[ADDR_WIDTH-1:0].
  - If the access is a word access and the new effective address is unaligned: DONE with fault code 01.
  - Else: go to ACCESS and clear the counter.
- ACCESS, all outputs driven from registered state:
  - mem_address = effective address.
  - Load: mem_read=1.
  - Word store: mem_write=1, wmask all ones, wdata = req_wdata.
  - Byte store: mem_write=1, wmask one-hot at the offset lane, wdata = req_wdata[7:0] replicated into every lane.
  - On mem_resp: capture the result and go to DONE.
    - Word load: result = mem_rdata.
    - Byte load: result = lane byte, sign- or zero-extended.
    - Store: result = 0.
- Timeout (TIMEOUT_CYCLES>0): the counter increments every PTR_RD/ACCESS cycle without mem_resp. When it reaches TIMEOUT_CYCLES: drop the strobes, go to DONE with fault code 10. If mem_resp arrives in the same cycle as expiry, the response wins.
- DONE: done=1, stall=0; fault/fault_code/load_data hold their latched values. Next state is always IDLE; no new request is accepted in DONE.
- stall = req_valid & (state != DONE).
- mem_read and mem_write are never both 1. Strobes are only asserted in PTR_RD or ACCESS.
- Latency, zero-wait memory: plain access = 3 cycles (IDLE, ACCESS, DONE); indirect = 4 cycles; misaligned fault = 2 cycles.
- Reset mid-access asynchronously drops strobes, stall and done to 0 and returns to IDLE. A mem_resp arriving in IDLE is ignored.
- req_valid falling while stall=1 is illegal; the latched request completes regardless.

Test Plan:
- Word load 0x3000, mem_resp in first ACCESS cycle, rdata 0xBEEF → mem_read 1 cycle; done on cycle 3, load_data=0xBEEF, stall high for cycles 1–2.
- Byte store 0xA5 to 0x1235, resp after 2 waits → wmask=2'b10, wdata=0xA5A5, mem_write 3 cycles, done with load_data=0.
- Byte load signed at 0x0101, rdata 0x80FF → load_data=0xFF80; unsigned → 0x0080.
- STI, pointer 0x2000 returns 0x4002, wdata 0x1234 → PTR_RD read 0x2000, then write 0x4002 with wmask=11, done on cycle 4. Repeat with pointer value 0x4003 → fault code 01 and no write.
- Word load at 0x0003 → no strobe, done cycle 2, fault=1, code 01. TIMEOUT_CYCLES=4, no resp → strobe 4 cycles, then done with fault code 10.
- Reset asserted in ACCESS with mem_read=1 → mem_read, stall and done are 0 immediately; next req_valid runs a normal access.
